// File: rtl/if_id_queue_pkg.sv
// Shared widths and the fetch-entry record for the IF/ID instruction queue.
package if_id_queue_pkg;

    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: one write port, one asynchronous read port, no reset.
module if_id_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with valid/ready on both sides and single-cycle flush.
// Define IF_ID_QUEUE_BYPASS_EN for zero-latency pass-through when the queue is empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int INST_WIDTH = INST_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INST_WIDTH + ADDR_WIDTH;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] cnt_q;
    entry_t               wr_entry;
    entry_t               rd_entry;
    logic                 stored_valid;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 rd_en;

    assign in_ready     = (cnt_q != CNT_WIDTH'(DEPTH));
    assign stored_valid = (cnt_q != '0);
    assign count        = cnt_q;
    assign wr_entry     = '{inst: in_inst, pc: in_pc};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = !stored_valid && in_valid && !flush;
        out_valid = stored_valid || bypass;
        out_inst  = '0;
        out_pc    = '0;
        if (stored_valid) begin
            out_inst = rd_entry.inst;
            out_pc   = rd_entry.pc;
        end else if (bypass) begin
            out_inst = in_inst;
            out_pc   = in_pc;
        end
    end

    // A bypassed entry the decoder takes immediately never touches storage.
    always_comb begin
        push  = in_valid && in_ready && !flush;
        pop   = stored_valid && out_ready && !flush;
        wr_en = push && !(bypass && out_ready);
        rd_en = pop;
    end
`else
    always_comb begin
        out_valid = stored_valid;
        out_inst  = stored_valid ? rd_entry.inst : '0;
        out_pc    = stored_valid ? rd_entry.pc   : '0;
    end

    always_comb begin
        push  = in_valid && in_ready && !flush;
        pop   = stored_valid && out_ready && !flush;
        wr_en = push;
        rd_en = pop;
    end
`endif

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt_q <= CNT_WIDTH'(DEPTH))
                else $error("if_id_queue: occupancy above DEPTH");
            assert (!(wr_en && !in_ready))
                else $error("if_id_queue: write while full");
        end
    end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand sequences and a queue-based random model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [31:0]   in_inst, in_pc;
    logic          in_ready, out_valid;
    logic [31:0]   out_inst, out_pc;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    if_id_queue #(.INST_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, in_valid, out_ready;
        logic [31:0] pc;
        logic        e_valid, e_ready;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];
    fetch_entry_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc == 32'h1000) ? 32'h0000_0013 : (pc ^ 32'hA5A5_0000);
    endfunction

    task automatic add(input logic r, f, iv, ordy, input logic [31:0] pc,
                       input logic ev, er, input logic [31:0] epc, input int ec);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.pc = pc;
        v.e_valid = ev; v.e_ready = er; v.e_pc = epc; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; out_ready = 0; in_inst = '0; in_pc = '0;
    endtask

    task automatic drive(input logic r, f, iv, ordy, input logic [31:0] pc);
        rst = r; flush = f; in_valid = iv; out_ready = ordy; in_pc = pc; in_inst = inst_of(pc);
    endtask

    // Expected outputs for the current (pre-edge) inputs, from the model queue.
    task automatic model_check(input string tag);
        logic        byp, ev;
        logic [31:0] ei, ep;
        byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && in_valid && !flush;
`endif
        ev = (mq.size() != 0) || byp;
        ei = (mq.size() != 0) ? mq[0].inst : (byp ? in_inst : 32'h0);
        ep = (mq.size() != 0) ? mq[0].pc   : (byp ? in_pc   : 32'h0);
        chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, "_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        chk({tag, "_inst"},  64'(out_inst), 64'(ei));
        chk({tag, "_pc"},    64'(out_pc),   64'(ep));
        chk({tag, "_count"}, 64'(count),    64'(mq.size()));
    endtask

    task automatic model_step();
        logic byp, do_push, do_pop;
        fetch_entry_t e;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && in_valid && out_ready;
`endif
        if (byp) return;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() != 0);
        e.inst = in_inst; e.pc = in_pc;
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
    endtask

    initial begin
        logic [31:0] next_pc;
        idle();

        // rst flush iv ordy pc | valid ready head_pc count
        add(1, 0, 0, 0, 32'h0,    0, 1, 32'h0,    0);
        add(0, 0, 1, 0, 32'h1000, 1, 1, 32'h1000, 1);
        add(0, 0, 0, 1, 32'h0,    0, 1, 32'h0,    0);
        add(0, 0, 1, 0, 32'h0,    1, 1, 32'h0,    1);
        add(0, 0, 1, 0, 32'h4,    1, 1, 32'h0,    2);
        add(0, 0, 1, 0, 32'h8,    1, 1, 32'h0,    3);
        add(0, 0, 1, 0, 32'hC,    1, 0, 32'h0,    4);
        add(0, 0, 1, 0, 32'h10,   1, 0, 32'h0,    4);
        add(0, 0, 1, 1, 32'h14,   1, 1, 32'h4,    3);
        add(0, 0, 1, 1, 32'h18,   1, 1, 32'h8,    3);
        add(0, 0, 0, 1, 32'h0,    1, 1, 32'hC,    2);
        add(0, 0, 1, 1, 32'h1C,   1, 1, 32'h18,   2);
        add(0, 0, 1, 0, 32'h20,   1, 1, 32'h18,   3);
        add(0, 1, 1, 1, 32'h24,   0, 1, 32'h0,    0);
        add(0, 0, 1, 0, 32'h28,   1, 1, 32'h28,   1);
        add(1, 0, 1, 1, 32'h2C,   0, 1, 32'h0,    0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].pc);
            @(posedge clk); #1;
            idle();
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].e_ready));
            chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vecs[i].e_pc));
            chk($sformatf("vec%0d_inst", i),  64'(out_inst),
                64'(vecs[i].e_valid ? inst_of(vecs[i].e_pc) : 32'h0));
            chk($sformatf("vec%0d_count", i), 64'(count),     64'(vecs[i].e_cnt));
        end

        // Fill to full, then stream 10 cycles with both sides active across the wrap.
        drive(1, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 1, 0, 32'(4 * k));
            @(posedge clk); #1;
        end
        idle(); #1;
        chk("fill_count", 64'(count), 64'(DEPTH));
        next_pc = 32'(4 * DEPTH);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 1, next_pc);
            #1;
            chk($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d_pc", k),    64'(out_pc),    64'(4 * k));
            if (in_ready) next_pc = next_pc + 32'h4;
            @(posedge clk); #1;
        end
        idle(); #1;
        chk("stream_count", 64'(count), 64'(DEPTH - 1));
        chk("stream_head",  64'(out_pc), 64'(40));

`ifdef IF_ID_QUEUE_BYPASS_EN
        drive(1, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 1, 1, 32'h2000);
        #1;
        chk("byp_valid", 64'(out_valid), 64'd1);
        chk("byp_pc",    64'(out_pc),    64'h2000);
        @(posedge clk); #1;
        idle(); #1;
        chk("byp_count", 64'(count), 64'd0);
        chk("byp_after", 64'(out_valid), 64'd0);
`endif

        // Randomised run against the queue model.
        drive(1, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(99) < 2, $urandom_range(99) < 5,
                  $urandom_range(99) < 60, $urandom_range(99) < 50,
                  32'(c) << 2);
            in_inst = $urandom;
            #1;
            model_check($sformatf("rnd%0d", c));
            model_step();
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
